// File: rtl/arc4_sched.sv
// ARC4 decrypt sequencer: runs init, ksa and prga in order, owns the shared
// single-port S memory mux and flags any engine that never comes back ready.
module arc4_sched #(
    parameter int KEY_W   = 24,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    input  logic [KEY_W-1:0]  key,
    output logic              err,
    output logic [KEY_W-1:0]  key_q,
    output logic              init_en,
    output logic              ksa_en,
    output logic              prga_en,
    input  logic              init_rdy,
    input  logic              ksa_rdy,
    input  logic              prga_rdy,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [7:0]        init_wrdata,
    input  logic [7:0]        ksa_wrdata,
    input  logic [7:0]        prga_wrdata,
    input  logic              init_wren,
    input  logic              ksa_wren,
    input  logic              prga_wren,
    output logic [ADDR_W-1:0] s_addr,
    output logic [7:0]        s_wrdata,
    output logic              s_wren,
    output logic [1:0]        phase
);

    localparam int WD_W = 12;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE,
        GO_INIT, GAP_INIT, RUN_INIT,
        GO_KSA,  GAP_KSA,  RUN_KSA,
        GO_PRGA, GAP_PRGA, RUN_PRGA
    } state_t;

    state_t             state_reg;
    logic [WD_W-1:0]    wd_reg;
    logic               rdy_reg;
    logic               err_reg;
    logic [KEY_W-1:0]   key_q_reg;
    logic               init_en_reg;
    logic               ksa_en_reg;
    logic               prga_en_reg;
    logic [1:0]         phase_reg;

    // Engine-indexed views of the three engine interfaces (0 init, 1 ksa, 2 prga)
    logic [ADDR_W-1:0]  eng_addr [3];
    logic [7:0]         eng_wrdata [3];
    logic [ADDR_W-1:0]  addr_masked [3];
    logic [7:0]         data_masked [3];
    logic [2:0]         eng_wren;
    logic [2:0]         eng_rdy;
    logic [2:0]         own;

    assign eng_addr[0]   = init_addr;
    assign eng_addr[1]   = ksa_addr;
    assign eng_addr[2]   = prga_addr;
    assign eng_wrdata[0] = init_wrdata;
    assign eng_wrdata[1] = ksa_wrdata;
    assign eng_wrdata[2] = prga_wrdata;
    assign eng_wren      = {prga_wren, ksa_wren, init_wren};
    assign eng_rdy       = {prga_rdy, ksa_rdy, init_rdy};

    // AND-OR mux: at most one engine owns the memory, phase 0 owns nothing
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_own
            assign own[gi]         = (phase_reg == 2'(gi + 1));
            assign addr_masked[gi] = own[gi] ? eng_addr[gi] : '0;
            assign data_masked[gi] = own[gi] ? eng_wrdata[gi] : '0;
        end
    endgenerate

    assign s_addr   = addr_masked[0] | addr_masked[1] | addr_masked[2];
    assign s_wrdata = data_masked[0] | data_masked[1] | data_masked[2];
    assign s_wren   = |(own & eng_wren);

    logic cur_rdy;
    logic in_gap;
    logic in_run;
    logic abort;

    assign cur_rdy = |(own & eng_rdy);
    assign in_gap  = (state_reg == GAP_INIT) || (state_reg == GAP_KSA) || (state_reg == GAP_PRGA);
    assign in_run  = (state_reg == RUN_INIT) || (state_reg == RUN_KSA) || (state_reg == RUN_PRGA);
    // A ready engine on the expiry cycle still counts as a normal finish
    assign abort   = (wd_reg == WD_LAST) && (in_gap || (in_run && !cur_rdy));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            wd_reg      <= '0;
            rdy_reg     <= 1'b1;
            err_reg     <= 1'b0;
            key_q_reg   <= '0;
            init_en_reg <= 1'b0;
            ksa_en_reg  <= 1'b0;
            prga_en_reg <= 1'b0;
            phase_reg   <= 2'd0;
        end else begin
            init_en_reg <= 1'b0;
            ksa_en_reg  <= 1'b0;
            prga_en_reg <= 1'b0;
            if (state_reg != IDLE) begin
                wd_reg <= wd_reg + 1'b1;
            end
            unique case (state_reg)
                IDLE: begin
                    if (en) begin
                        key_q_reg   <= key;
                        err_reg     <= 1'b0;
                        rdy_reg     <= 1'b0;
                        init_en_reg <= 1'b1;
                        phase_reg   <= 2'd1;
                        wd_reg      <= '0;
                        state_reg   <= GO_INIT;
                    end
                end
                GO_INIT:  state_reg <= GAP_INIT;
                GAP_INIT: state_reg <= RUN_INIT;
                RUN_INIT: begin
                    if (init_rdy) begin
                        ksa_en_reg <= 1'b1;
                        phase_reg  <= 2'd2;
                        wd_reg     <= '0;
                        state_reg  <= GO_KSA;
                    end
                end
                GO_KSA:   state_reg <= GAP_KSA;
                GAP_KSA:  state_reg <= RUN_KSA;
                RUN_KSA: begin
                    if (ksa_rdy) begin
                        prga_en_reg <= 1'b1;
                        phase_reg   <= 2'd3;
                        wd_reg      <= '0;
                        state_reg   <= GO_PRGA;
                    end
                end
                GO_PRGA:  state_reg <= GAP_PRGA;
                GAP_PRGA: state_reg <= RUN_PRGA;
                RUN_PRGA: begin
                    if (prga_rdy) begin
                        rdy_reg   <= 1'b1;
                        phase_reg <= 2'd0;
                        state_reg <= IDLE;
                    end
                end
                default:  state_reg <= IDLE;
            endcase
            if (abort) begin
                err_reg   <= 1'b1;
                rdy_reg   <= 1'b1;
                phase_reg <= 2'd0;
                state_reg <= IDLE;
            end
        end
    end

    assign rdy     = rdy_reg;
    assign err     = err_reg;
    assign key_q   = key_q_reg;
    assign init_en = init_en_reg;
    assign ksa_en  = ksa_en_reg;
    assign prga_en = prga_en_reg;
    assign phase   = phase_reg;

endmodule

// File: tb/tb_arc4_sched.sv
// Bench for arc4_sched: two instances (default TIMEOUT and TIMEOUT=16) driven by
// behavioural engine models, checked cycle by cycle against a schedule model.
module tb_arc4_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v [2];
    logic        en_v [2];
    logic [23:0] key_v [2];
    logic        rdy_v [2];
    logic        err_v [2];
    logic [23:0] key_q_v [2];
    logic        init_en_v [2];
    logic        ksa_en_v [2];
    logic        prga_en_v [2];
    logic        eng_en_v [2][3];
    logic        erdy [2][3] = '{default: 1'b1};
    logic [7:0]  eaddr [2][3];
    logic [7:0]  ewd [2][3];
    logic        ewren [2][3];
    logic [7:0]  s_addr_v [2];
    logic [7:0]  s_wd_v [2];
    logic        s_wren_v [2];
    logic [1:0]  phase_v [2];

    int          cnt [2][3] = '{default: 0};
    int          run_len [2][3] = '{default: 1};
    logic [23:0] key_m [2] = '{default: 24'h0};
    logic        err_m [2] = '{default: 1'b0};
    int          n_checks = 0;
    int          n_pass = 0;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            arc4_sched #(.KEY_W(24), .ADDR_W(8), .TIMEOUT(gi == 0 ? 4096 : 16)) dut (
                .clk(clk), .rst(rst_v[gi]), .en(en_v[gi]), .rdy(rdy_v[gi]),
                .key(key_v[gi]), .err(err_v[gi]), .key_q(key_q_v[gi]),
                .init_en(init_en_v[gi]), .ksa_en(ksa_en_v[gi]), .prga_en(prga_en_v[gi]),
                .init_rdy(erdy[gi][0]), .ksa_rdy(erdy[gi][1]), .prga_rdy(erdy[gi][2]),
                .init_addr(eaddr[gi][0]), .ksa_addr(eaddr[gi][1]), .prga_addr(eaddr[gi][2]),
                .init_wrdata(ewd[gi][0]), .ksa_wrdata(ewd[gi][1]), .prga_wrdata(ewd[gi][2]),
                .init_wren(ewren[gi][0]), .ksa_wren(ewren[gi][1]), .prga_wren(ewren[gi][2]),
                .s_addr(s_addr_v[gi]), .s_wrdata(s_wd_v[gi]), .s_wren(s_wren_v[gi]),
                .phase(phase_v[gi])
            );
            assign eng_en_v[gi][0] = init_en_v[gi];
            assign eng_en_v[gi][1] = ksa_en_v[gi];
            assign eng_en_v[gi][2] = prga_en_v[gi];
        end
    endgenerate

    // Engine model: rdy drops the cycle after en and stays low for run_len cycles
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int e = 0; e < 3; e++) begin
                if (eng_en_v[d][e]) begin
                    erdy[d][e] <= 1'b0;
                    cnt[d][e]  <= run_len[d][e] - 1;
                end else if (!erdy[d][e]) begin
                    if (cnt[d][e] == 0) erdy[d][e] <= 1'b1;
                    else cnt[d][e] <= cnt[d][e] - 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int d, input int k,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s dut%0d cycle %0d: observed %0h expected %0h", name, d, k, obs, exp);
    endtask

    task automatic drive_random(input int d);
        for (int e = 0; e < 3; e++) begin
            eaddr[d][e] = 8'($urandom);
            ewd[d][e]   = 8'($urandom);
            ewren[d][e] = 1'($urandom);
        end
    endtask

    task automatic wait_engines(input int d);
        int n = 0;
        while (!(erdy[d][0] && erdy[d][1] && erdy[d][2] && rdy_v[d]) && n < 3000) begin
            @(posedge clk); #2;
            n++;
        end
        chk("idle_wait_in_budget", d, n, 32'(n < 3000), 32'd1);
    endtask

    task automatic check_reset_state(input int d, input int k);
        chk("rst_rdy", d, k, 32'(rdy_v[d]), 32'd1);
        chk("rst_err", d, k, 32'(err_v[d]), 32'd0);
        chk("rst_key_q", d, k, 32'(key_q_v[d]), 32'd0);
        chk("rst_phase", d, k, 32'(phase_v[d]), 32'd0);
        chk("rst_s_wren", d, k, 32'(s_wren_v[d]), 32'd0);
        chk("rst_s_addr", d, k, 32'(s_addr_v[d]), 32'd0);
        chk("rst_s_wrdata", d, k, 32'(s_wd_v[d]), 32'd0);
        chk("rst_en_pulses", d, k, {29'd0, prga_en_v[d], ksa_en_v[d], init_en_v[d]}, 32'd0);
    endtask

    // One schedule: phase p lasts run time + 2 cycles, or TIMEOUT cycles and ends in error
    task automatic run(input int d, input logic [23:0] kin, input int t0, input int t1,
                       input int t2, input int busy_at, input int rst_at);
        int tmo, cur, np, last, ph;
        int st [3];
        int ln [3];
        int tt [3];
        logic e_exp;
        logic [7:0] x_addr, x_data;
        logic x_wren;
        logic [2:0] x_en;
        tmo = (d == 0) ? 4096 : 16;
        tt[0] = t0; tt[1] = t1; tt[2] = t2;
        cur = 1; np = 0; e_exp = 1'b0;
        for (int p = 0; p < 3; p++) begin
            if (!e_exp) begin
                st[p] = cur;
                if (tt[p] <= tmo - 2) ln[p] = tt[p] + 2;
                else begin ln[p] = tmo; e_exp = 1'b1; end
                cur += ln[p];
                np = p + 1;
            end
        end
        last = cur - 1;
        wait_engines(d);
        for (int e = 0; e < 3; e++) run_len[d][e] = tt[e];
        drive_random(d);
        chk("start_rdy", d, 0, 32'(rdy_v[d]), 32'd1);
        chk("start_err", d, 0, 32'(err_v[d]), 32'(err_m[d]));
        chk("start_key_q", d, 0, 32'(key_q_v[d]), 32'(key_m[d]));
        en_v[d] = 1'b1;
        key_v[d] = kin;
        for (int k = 1; k <= last + 1; k++) begin
            @(posedge clk); #1;
            en_v[d]  = (k == busy_at);
            key_v[d] = (k == busy_at) ? 24'hFFFFFF : 24'($urandom);
            rst_v[d] = (k == rst_at);
            drive_random(d);
            if (k == busy_at) begin
                ewren[d][0] = 1'b1; ewren[d][2] = 1'b1;
                eaddr[d][0] = 8'hAA; eaddr[d][2] = 8'hAA;
            end
            if (k == rst_at + 1) begin
                for (int e = 0; e < 3; e++) ewren[d][e] = 1'b1;
            end
            #1;
            if (k == rst_at + 1) begin
                check_reset_state(d, k);
                rst_v[d] = 1'b0;
                key_m[d] = 24'h0;
                err_m[d] = 1'b0;
                return;
            end
            ph = 0;
            x_en = 3'b000;
            for (int p = 0; p < np; p++) begin
                if (k >= st[p] && k < st[p] + ln[p]) ph = p + 1;
                if (k == st[p]) x_en[p] = 1'b1;
            end
            x_addr = (ph == 0) ? 8'h00 : eaddr[d][ph-1];
            x_data = (ph == 0) ? 8'h00 : ewd[d][ph-1];
            x_wren = (ph == 0) ? 1'b0 : ewren[d][ph-1];
            chk("rdy", d, k, 32'(rdy_v[d]), 32'(k > last));
            chk("phase", d, k, 32'(phase_v[d]), 32'(ph));
            chk("err", d, k, 32'(err_v[d]), 32'((k > last) && e_exp));
            chk("key_q", d, k, 32'(key_q_v[d]), 32'(kin));
            chk("en_pulses", d, k, {29'd0, prga_en_v[d], ksa_en_v[d], init_en_v[d]}, 32'(x_en));
            chk("s_addr", d, k, 32'(s_addr_v[d]), 32'(x_addr));
            chk("s_wrdata", d, k, 32'(s_wd_v[d]), 32'(x_data));
            chk("s_wren", d, k, 32'(s_wren_v[d]), 32'(x_wren));
        end
        key_m[d] = kin;
        err_m[d] = e_exp;
        $display("run dut%0d key=%06h t=%0d/%0d/%0d busy=%0d cycles err=%0d", d, kin, t0, t1, t2, last, e_exp);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b1;
            en_v[d]  = 1'b1;
            key_v[d] = 24'hABCDEF;
            drive_random(d);
            for (int e = 0; e < 3; e++) ewren[d][e] = 1'b1;
        end
        @(posedge clk); #2;
        for (int d = 0; d < 2; d++) begin
            check_reset_state(d, 0);
            rst_v[d] = 1'b0;
            en_v[d]  = 1'b0;
        end
        $display("reset with en held: checked both instances");
        @(posedge clk); #2;

        // Normal run with a rejected busy en and mux isolation inside RUN_KSA
        run(0, 24'h00033C, 256, 768, 1024, 300, -1);
        // Reset in the middle of RUN_PRGA
        run(0, 24'($urandom), 20, 30, 40, -1, 80);
        // Hung ksa engine trips the watchdog; the next run clears err
        run(1, 24'h123456, 5, 1000, 5, -1, -1);
        run(1, 24'h00033C, 3, 5, 2, -1, -1);
        // Ready on the expiry cycle wins; one cycle later is an error
        run(1, 24'($urandom), 14, 14, 14, -1, -1);
        run(1, 24'($urandom), 3, 15, 3, -1, -1);
        for (int i = 0; i < 8; i++) begin
            run(1, 24'($urandom), int'($urandom_range(1, 16)), int'($urandom_range(1, 16)),
                int'($urandom_range(1, 16)), -1, -1);
        end
        for (int i = 0; i < 2; i++) begin
            run(0, 24'($urandom), int'($urandom_range(1, 50)), int'($urandom_range(1, 50)),
                int'($urandom_range(1, 50)), -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/arc4_sched.md
Name: arc4_sched

Overview:
- Top-level sequencer for the ARC4 decrypt path: runs the init, ksa and prga engines in order and arbitrates the single-port S memory among them.
- Sits between the ARC4 wrapper's en/rdy handshake and the three engines.
- Latches the key and passes it to ksa and prga.
- Flags an engine that never returns to ready.

Parameters:
- KEY_W, 24, key width in bits.
- ADDR_W, 8, S memory address width.
- TIMEOUT, 4096, maximum cycles per phase before error; 12-bit watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- en  in  1  start request; accepted only when rdy=1
- rdy  out  1  idle and able to accept en
- key  in  KEY_W  key, sampled on the accepted en
- err  out  1  sticky watchdog error; cleared by the next accepted en or by rst
- key_q  out  KEY_W  latched key, driven to ksa and prga
- init_en / ksa_en / prga_en  out  1 each  engine start pulses
- init_rdy / ksa_rdy / prga_rdy  in  1 each  engine ready
- init_addr, ksa_addr, prga_addr  in  ADDR_W each  engine S address
- init_wrdata, ksa_wrdata, prga_wrdata  in  8 each  engine S write data
- init_wren, ksa_wren, prga_wren  in  1 each  engine S write enable
- s_addr  out  ADDR_W  S memory address
- s_wrdata  out  8  S memory write data
- s_wren  out  1  S memory write enable
- phase  out  2  current memory owner: 0 none, 1 init, 2 ksa, 3 prga

Behaviour:
- Reset values:
  - rdy=1, err=0, key_q=0.
  - All *_en=0; s_addr=0, s_wrdata=0, s_wren=0; phase=0.
  - State=IDLE, watchdog=0.
- Handshake (all interfaces):
  - A start is a single-cycle en pulse while rdy=1.
  - en while rdy=0 is ignored.
  - Engines drop rdy the cycle after their en and raise it when finished.
- States and transitions:
  - IDLE: rdy=1. On en, latch key into key_q, clear err, go to GO_INIT.
  - GO_INIT: init_en=1 for exactly this cycle; phase=1; go to GAP_INIT.
  - GAP_INIT: one cycle in which init_rdy is ignored; go to RUN_INIT.
  - RUN_INIT: wait for init_rdy=1, then go to GO_KSA.
  - GO_KSA / GAP_KSA / RUN_KSA: same pattern with ksa_en, ksa_rdy, phase=2.
  - GO_PRGA / GAP_PRGA / RUN_PRGA: same pattern with prga_en, prga_rdy, phase=3.
  - On prga_rdy=1 in RUN_PRGA go to IDLE. rdy rises on the following cycle.
- rdy is registered and is 0 from the cycle after en was accepted through the end of RUN_PRGA.
- Memory mux:
  - Combinational select on phase: s_addr, s_wrdata and s_wren come from the owning engine.
  - phase=0 forces s_wren=0, s_addr=0 and s_wrdata=0.
  - Writes from a non-owning engine are never forwarded.
  - Memory read data is fanned out to all engines externally; no mux is needed on it.
- Phase boundary:
  - phase changes on the GO_* cycle.
  - The previous engine is already ready, so its last write has been committed.
  - No two engines ever own the memory in the same cycle.
- Watchdog:
  - Counter clears on every GO_* cycle and increments in GAP_* and RUN_*.
  - If it reaches TIMEOUT-1 without the engine returning rdy: set err=1, go to IDLE, set phase=0, drop all *_en.
  - Engines are not reset by this block.
- Reset mid-operation: rst in any state returns all outputs to reset values on the next edge, regardless of en.
- Simultaneous events:
  - en and rst together: rst wins.
  - Engine rdy=1 on the same cycle the watchdog expires: rdy wins, no error.
- Latency: with engine run times Ti, Tk and Tp cycles, the schedule spans 6+Ti+Tk+Tp cycles from the accepted en to rdy=1.

Test Plan:
- Normal run:
  - Stimulus: rst 1 cycle; key=24'h00033C, en pulse; model engines return rdy after 256, 768 and 1024 cycles.
  - Response: init_en, ksa_en and prga_en each 1 cycle wide, in order; phase goes 1→2→3→0; key_q=24'h00033C; rdy=1 at cycle 2054; err=0.
- Mux isolation:
  - Stimulus: during phase 2, drive init_wren=1 and prga_wren=1 with addr=8'hAA.
  - Response: s_wren follows ksa_wren only; s_addr=ksa_addr.
- Busy ignore:
  - Stimulus: a second en with key=24'hFFFFFF during RUN_KSA.
  - Response: no new init_en; key_q remains 24'h00033C.
- Watchdog:
  - Stimulus: TIMEOUT=16; ksa_rdy is held at 0.
  - Response: err=1 and rdy=1 after the watchdog expires (16 cycles after GO_KSA); prga_en never pulses; phase=0.
- Error clear:
  - Stimulus: after the watchdog test, pulse en with all engines well-behaved.
  - Response: err=0 on the cycle after en; a full sequence completes.
- Reset mid-op:
  - Stimulus: assert rst in RUN_PRGA.
  - Response: next cycle rdy=1, phase=0, s_wren=0, err=0, key_q=0.
